// File: rtl/ocp_slave_mem_if.sv
// OCP point-to-point link between the master bridge and the slave memory.
// Slave modport is the view taken by ocp_slave_mem.
interface ocp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [2:0]            m_cmd;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_resp_accept;
  logic                  s_cmd_accept;
  logic [1:0]            s_resp;
  logic [DATA_WIDTH-1:0] s_data;

  modport slave (
    input  m_cmd,
    input  m_addr,
    input  m_data,
    input  m_resp_accept,
    output s_cmd_accept,
    output s_resp,
    output s_data
  );

  modport master (
    output m_cmd,
    output m_addr,
    output m_data,
    output m_resp_accept,
    input  s_cmd_accept,
    input  s_resp,
    input  s_data
  );
endinterface

// File: rtl/ocp_slave_mem.sv
// OCP slave endpoint serving one command at a time from a register array.
// Define OCP_SLAVE_MEM_ADDR_CHECK_EN to answer out-of-range addresses with ERR.
module ocp_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int DEPTH       = 2**ADDR_WIDTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  ocp_if.slave        s_ocp,
  output logic        busy,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  localparam int unsigned DEPTH_U = DEPTH;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [2:0] CMD_WR = 3'b001;
  localparam logic [2:0] CMD_RD = 3'b010;
  localparam logic [1:0] R_NULL = 2'b00;
  localparam logic [1:0] R_DVA  = 2'b01;
  localparam logic [1:0] R_ERR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [15:0]           wrc_q, wrc_d;
  logic [15:0]           rdc_q, rdc_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IW-1:0]         idx;
  logic                  addr_ok;
  logic                  go_resp;
  logic                  mem_we;

  assign idx = IW'(32'(addr_q) % DEPTH_U);

`ifdef OCP_SLAVE_MEM_ADDR_CHECK_EN
  assign addr_ok = (32'(addr_q) < DEPTH_U);
`else
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    wrc_d   = wrc_q;
    rdc_d   = rdc_q;
    go_resp = 1'b0;
    mem_we  = 1'b0;
    if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (s_ocp.m_cmd == CMD_WR || s_ocp.m_cmd == CMD_RD) begin
            wr_d    = (s_ocp.m_cmd == CMD_WR);
            addr_d  = s_ocp.m_addr;
            data_d  = s_ocp.m_data;
            state_d = ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            go_resp = 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) go_resp = 1'b1;
          else cnt_d = cnt_q - 4'd1;
        end
        ST_RESP: begin
          if (s_ocp.m_resp_accept && resp_q != R_NULL) begin
            resp_d  = R_NULL;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Access, response and counter all land on the edge entering RESP
    if (go_resp) begin
      state_d = ST_RESP;
      if (!addr_ok) begin
        resp_d  = R_ERR;
        rdata_d = '0;
      end else if (wr_q) begin
        resp_d  = R_DVA;
        rdata_d = '0;
        wrc_d   = wrc_q + 16'd1;
        mem_we  = reset;
      end else begin
        resp_d  = R_DVA;
        rdata_d = mem_q[idx];
        rdc_d   = rdc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= 4'd0;
      resp_q  <= R_NULL;
      rdata_q <= '0;
      wrc_q   <= 16'd0;
      rdc_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      wrc_q   <= wrc_d;
      rdc_q   <= rdc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= data_q;
  end

  assign s_ocp.s_cmd_accept = (state_q == ST_ACCEPT);
  assign s_ocp.s_resp       = resp_q;
  assign s_ocp.s_data       = rdata_q;
  assign busy               = (state_q != ST_IDLE);
  assign wr_count           = wrc_q;
  assign rd_count           = rdc_q;

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Randomized bench for ocp_slave_mem against a transaction-level model.
// DEPTH=16 so that addresses 16..31 exercise range handling.
module tb_ocp_slave_mem;

  localparam int W  = 2;
  localparam int DP = 16;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        busy;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  ocp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  ocp_slave_mem #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .DEPTH(DP),
    .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .s_ocp(bus),
    .busy(busy),
    .wr_count(wr_count),
    .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mdl [DP];
  bit          vld [DP];
  int          ewr = 0;
  int          erd = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt();
    chk("wr_count", 32'(wr_count), 32'(ewr % 65536));
    chk("rd_count", 32'(rd_count), 32'(erd % 65536));
  endtask

  task automatic txn(input bit wr, input logic [4:0] a,
                     input logic [31:0] d, input int hold,
                     input bit noise, input int frz);
    logic [1:0]  er;
    logic [31:0] ed;
    bit          dchk;
    bit          ok;
    int          cyc;
    int          i;
    i  = int'(a) % DP;
    ok = 1'b1;
`ifdef OCP_SLAVE_MEM_ADDR_CHECK_EN
    ok = (int'(a) < DP);
`endif
    if (!ok) begin
      er = 2'b11; ed = '0; dchk = 1'b1;
    end else if (wr) begin
      er = 2'b01; ed = '0; dchk = 1'b1;
      mdl[i] = d; vld[i] = 1'b1; ewr++;
    end else begin
      er = 2'b01; ed = mdl[i]; dchk = vld[i]; erd++;
    end
    @(negedge clk);
    bus.m_cmd  = wr ? 3'b001 : 3'b010;
    bus.m_addr = a;
    bus.m_data = d;
    bus.m_resp_accept = (hold == 0);
    @(negedge clk);
    bus.m_cmd  = noise ? (wr ? 3'b010 : 3'b001) : 3'b000;
    bus.m_addr = 5'($urandom);
    bus.m_data = $urandom;
    chk("accept", 32'(bus.s_cmd_accept), 32'd1);
    chk("busy_acc", 32'(busy), 32'd1);
    if (frz > 0) begin
      enable = 1'b0;
      repeat (frz) begin
        @(negedge clk);
        chk("accept_frozen", 32'(bus.s_cmd_accept), 32'd1);
      end
      enable = 1'b1;
    end
    cyc = 1 + frz;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (bus.s_resp != 2'b00 || cyc >= 40) break;
      chk("no_accept", 32'(bus.s_cmd_accept), 32'd0);
    end
    bus.m_cmd = 3'b000;
    chk("latency", 32'(cyc), 32'(2 + W + frz));
    chk("resp", 32'(bus.s_resp), 32'(er));
    if (dchk) chk("data", bus.s_data, ed);
    chk_cnt();
    repeat (hold) begin
      @(negedge clk);
      chk("hold_resp", 32'(bus.s_resp), 32'(er));
      if (dchk) chk("hold_data", bus.s_data, ed);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    bus.m_resp_accept = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("resp_clr", 32'(bus.s_resp), 32'd0);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    bus.m_cmd = 3'b000;
    bus.m_addr = '0;
    bus.m_data = '0;
    bus.m_resp_accept = 1'b0;
    for (int k = 0; k < DP; k++) vld[k] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_accept", 32'(bus.s_cmd_accept), 32'd0);
    chk("rst_resp", 32'(bus.s_resp), 32'd0);
    chk("rst_data", bus.s_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_cnt();
    reset = 1'b1;

    txn(1'b1, 5'd5, 32'hA5A5_0001, 0, 1'b0, 0);
    txn(1'b0, 5'd5, 32'h0, 0, 1'b0, 0);
    txn(1'b0, 5'd5, 32'h0, 10, 1'b0, 0);
    txn(1'b1, 5'd7, 32'hDEAD_BEEF, 1, 1'b1, 0);
    txn(1'b0, 5'd7, 32'h0, 0, 1'b1, 0);
    txn(1'b1, 5'd9, 32'h0BAD_F00D, 0, 1'b0, 3);
    txn(1'b0, 5'd9, 32'h0, 2, 1'b0, 3);

    txn(1'b1, 5'd4, 32'h4444_4444, 0, 1'b0, 0);
    txn(1'b1, 5'd20, 32'h2020_2020, 0, 1'b0, 0);
    txn(1'b0, 5'd4, 32'h0, 0, 1'b0, 0);

    // Reset during WAIT of a write: write lost, counters cleared
    txn(1'b1, 5'd3, 32'h1111_1111, 0, 1'b0, 0);
    @(negedge clk);
    bus.m_cmd  = 3'b001;
    bus.m_addr = 5'd3;
    bus.m_data = 32'h2222_2222;
    @(negedge clk);
    bus.m_cmd = 3'b000;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    ewr = 0;
    erd = 0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_accept", 32'(bus.s_cmd_accept), 32'd0);
    chk("midrst_resp", 32'(bus.s_resp), 32'd0);
    chk("midrst_data", bus.s_data, 32'd0);
    chk_cnt();
    @(negedge clk);
    reset = 1'b1;
    txn(1'b0, 5'd3, 32'h0, 0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      txn(1'($urandom), 5'($urandom), $urandom,
          int'($urandom_range(0, 3)), 1'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
